// File: rtl/channel_index_sequencer.sv
// channel_index_sequencer: scans a captured channel-enable mask one bit per clock
// into a compact ascending table of enabled channel indexes, then walks it with a
// valid/ready iterator.
//
// Ports:
//   i_clk             single rising-edge clock
//   i_reset           synchronous, active-high reset
//   i_enable_mask     channel enables (bit c = channel c), sampled with i_enable_update
//   i_enable_update   1-cycle strobe: capture mask and rebuild the table
//   o_busy            table rebuild in progress
//   o_map_valid       table/count valid for the captured mask
//   o_enabled_count   number of enabled channels in the captured mask
//   o_index_table     slot k at [k*IW +: IW] = k-th enabled channel, unused slots 0
//   o_iter_index      current iterator index
//   o_iter_valid      iterator output valid
//   i_iter_ready      consumer accepts o_iter_index on o_iter_valid && i_iter_ready
//   o_iter_last       current index is the last enabled channel before wrap
module channel_index_sequencer #(
    parameter int NUM_CHANNELS = 8,
    localparam int IW = $clog2(NUM_CHANNELS),
    localparam int CW = $clog2(NUM_CHANNELS + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_CHANNELS-1:0]    i_enable_mask,
    input  logic                       i_enable_update,
    output logic                       o_busy,
    output logic                       o_map_valid,
    output logic [CW-1:0]              o_enabled_count,
    output logic [NUM_CHANNELS*IW-1:0] o_index_table,
    output logic [IW-1:0]              o_iter_index,
    output logic                       o_iter_valid,
    input  logic                       i_iter_ready,
    output logic                       o_iter_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_READY
    } state_t;

    localparam logic [IW-1:0] LAST_PTR = IW'(NUM_CHANNELS - 1);

    state_t                  r_state;
    logic [NUM_CHANNELS-1:0] r_mask;
    logic [IW-1:0]           r_ptr;
    logic [CW-1:0]           r_count;
    logic [IW-1:0]           r_tab [NUM_CHANNELS];
    logic [IW-1:0]           r_slot;
    logic                    r_busy;
    logic                    r_map_valid;
    logic [IW-1:0]           r_iter_index;
    logic                    r_iter_valid;
    logic                    r_iter_last;

    logic                    w_accept;
    logic                    w_nonempty;
    logic                    w_slot_is_last;
    logic [IW-1:0]           w_slot_next;
    logic [CW-1:0]           w_last_slot;
    logic [NUM_CHANNELS*IW-1:0] w_table;

    // Iterator bookkeeping: the slot advances on an accepted transfer and
    // wraps to 0 after the last enabled entry.
    always_comb begin
        w_accept       = r_iter_valid && i_iter_ready;
        w_nonempty     = (r_count != '0);
        w_last_slot    = r_count - CW'(1);
        w_slot_is_last = (CW'(r_slot) == w_last_slot);
        w_slot_next    = r_slot;
        if (w_accept) begin
            if (w_slot_is_last) begin
                w_slot_next = '0;
            end else begin
                w_slot_next = r_slot + IW'(1);
            end
        end
    end

    always_comb begin
        w_table = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            w_table[k*IW +: IW] = r_tab[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_ptr        <= '0;
            r_count      <= '0;
            r_slot       <= '0;
            r_busy       <= 1'b0;
            r_map_valid  <= 1'b0;
            r_iter_index <= '0;
            r_iter_valid <= 1'b0;
            r_iter_last  <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                r_tab[k] <= '0;
            end
        end else if (i_enable_update) begin
            // A new mask restarts the scan from any state; a transfer
            // accepted on this same edge is simply complete.
            r_state      <= S_SCAN;
            r_mask       <= i_enable_mask;
            r_ptr        <= '0;
            r_count      <= '0;
            r_slot       <= '0;
            r_busy       <= 1'b1;
            r_map_valid  <= 1'b0;
            r_iter_index <= '0;
            r_iter_valid <= 1'b0;
            r_iter_last  <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                r_tab[k] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_SCAN: begin
                    // r_count < NUM_CHANNELS whenever a bit is still
                    // to be appended, so its low bits address the table.
                    if (r_mask[r_ptr]) begin
                        r_tab[r_count[IW-1:0]] <= r_ptr;
                        r_count <= r_count + CW'(1);
                    end
                    if (r_ptr == LAST_PTR) begin
                        r_state     <= S_READY;
                        r_busy      <= 1'b0;
                        r_map_valid <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + IW'(1);
                    end
                end
                S_READY: begin
                    // Outputs are registered from the next slot so that
                    // o_iter_index always equals table[r_slot].
                    r_slot       <= w_slot_next;
                    r_iter_valid <= w_nonempty;
                    if (w_nonempty) begin
                        r_iter_index <= r_tab[w_slot_next];
                        r_iter_last  <= (CW'(w_slot_next) == w_last_slot);
                    end else begin
                        r_iter_index <= '0;
                        r_iter_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_map_valid     = r_map_valid;
    assign o_enabled_count = r_count;
    assign o_index_table   = w_table;
    assign o_iter_index    = r_iter_index;
    assign o_iter_valid    = r_iter_valid;
    assign o_iter_last     = r_iter_last;

endmodule

// File: tb/tb_channel_index_sequencer.sv
// tb_channel_index_sequencer: directed checks of the mask-to-index table
// and the valid/ready iterator of channel_index_sequencer (N=8).
module tb_channel_index_sequencer;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int CW = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    enable_mask;
    logic            enable_update;
    logic            busy;
    logic            map_valid;
    logic [CW-1:0]   enabled_count;
    logic [N*IW-1:0] index_table;
    logic [IW-1:0]   iter_index;
    logic            iter_valid;
    logic            iter_ready;
    logic            iter_last;

    int errors;
    int checks;

    channel_index_sequencer #(.NUM_CHANNELS(N)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_enable_mask   (enable_mask),
        .i_enable_update (enable_update),
        .o_busy          (busy),
        .o_map_valid     (map_valid),
        .o_enabled_count (enabled_count),
        .o_index_table   (index_table),
        .o_iter_index    (iter_index),
        .o_iter_valid    (iter_valid),
        .i_iter_ready    (iter_ready),
        .o_iter_last     (iter_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N*IW-1:0] zero_tab;
        zero_tab = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, map_valid, enabled_count, iter_index, iter_valid, iter_last} !== '0
            || index_table !== zero_tab) begin
            errors++;
            $display("FAIL reset_state: busy=%b mv=%b cnt=%0d tab=%h idx=%0d v=%b l=%b",
                     busy, map_valid, enabled_count, index_table,
                     iter_index, iter_valid, iter_last);
        end
        enable_mask   = 8'hA6;
        enable_update = 1'b1;
        tick();
        enable_update = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prescan_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, map_valid, enabled_count, iter_index, iter_valid, iter_last} !== '0
            || index_table !== zero_tab) begin
            errors++;
            $display("FAIL reset_midscan: busy=%b mv=%b cnt=%0d tab=%h idx=%0d v=%b",
                     busy, map_valid, enabled_count, index_table, iter_index, iter_valid);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b0 || map_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: busy=%b mv=%b want 0 0", busy, map_valid);
        end
    endtask

    task automatic test_map();
        logic [N*IW-1:0] exp_tab;
        int busy_cycles;
        exp_tab = '0;
        exp_tab[0+:3] = 3'd1;
        exp_tab[3+:3] = 3'd2;
        exp_tab[6+:3] = 3'd5;
        exp_tab[9+:3] = 3'd7;
        enable_mask   = 8'b1010_0110;
        enable_update = 1'b1;
        tick();
        enable_update = 1'b0;
        enable_mask   = 8'h00;
        busy_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            if (busy === 1'b1 && map_valid === 1'b0) busy_cycles++;
            tick();
        end
        if (busy === 1'b1 && map_valid === 1'b0) busy_cycles++;
        checks++;
        if (busy_cycles != 8) begin
            errors++;
            $display("FAIL map_busy_cycles: got %0d want 8", busy_cycles);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || map_valid !== 1'b1) begin
            errors++;
            $display("FAIL map_latency: busy=%b mv=%b want 0 1", busy, map_valid);
        end
        checks++;
        if (enabled_count !== 4'd4) begin
            errors++;
            $display("FAIL map_count: got %0d want 4", enabled_count);
        end
        checks++;
        if (index_table !== exp_tab) begin
            errors++;
            $display("FAIL map_table: got %h want %h", index_table, exp_tab);
        end
        checks++;
        if (iter_valid !== 1'b0) begin
            errors++;
            $display("FAIL map_iter_delay: iter_valid=%b want 0", iter_valid);
        end
    endtask

    task automatic test_iter();
        logic [IW-1:0] seq [4];
        seq[0] = 3'd1;
        seq[1] = 3'd2;
        seq[2] = 3'd5;
        seq[3] = 3'd7;
        tick();
        checks++;
        if (iter_valid !== 1'b1 || iter_index !== 3'd1) begin
            errors++;
            $display("FAIL iter_first: v=%b idx=%0d want 1 1", iter_valid, iter_index);
        end
        iter_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (iter_valid !== 1'b1 || iter_index !== seq[i%4]
                || iter_last !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL iter_seq[%0d]: v=%b idx=%0d last=%b want 1 %0d %b",
                         i, iter_valid, iter_index, iter_last, seq[i%4], (i % 4 == 3));
            end
            tick();
        end
        iter_ready = 1'b0;
    endtask

    task automatic test_empty();
        int seen_valid;
        enable_mask   = 8'h00;
        enable_update = 1'b1;
        tick();
        enable_update = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (map_valid !== 1'b1 || enabled_count !== 4'd0 || index_table !== '0) begin
            errors++;
            $display("FAIL empty_map: mv=%b cnt=%0d tab=%h want 1 0 0",
                     map_valid, enabled_count, index_table);
        end
        iter_ready = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (iter_valid !== 1'b0) seen_valid++;
        end
        iter_ready = 1'b0;
        checks++;
        if (seen_valid != 0) begin
            errors++;
            $display("FAIL empty_iter: iter_valid high %0d cycles want 0", seen_valid);
        end
    endtask

    task automatic test_restart();
        logic [N*IW-1:0] exp_tab;
        exp_tab = '0;
        for (int k = 0; k < N; k++) exp_tab[k*IW +: IW] = IW'(k);
        enable_mask   = 8'h0F;
        enable_update = 1'b1;
        tick();
        enable_update = 1'b0;
        tick();
        tick();
        tick();
        enable_mask   = 8'hFF;
        enable_update = 1'b1;
        tick();
        enable_update = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (busy !== 1'b1 || map_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_busy: busy=%b mv=%b want 1 0", busy, map_valid);
        end
        tick();
        checks++;
        if (map_valid !== 1'b1 || busy !== 1'b0 || enabled_count !== 4'd8) begin
            errors++;
            $display("FAIL restart_done: mv=%b busy=%b cnt=%0d want 1 0 8",
                     map_valid, busy, enabled_count);
        end
        checks++;
        if (index_table !== exp_tab) begin
            errors++;
            $display("FAIL restart_table: got %h want %h", index_table, exp_tab);
        end
    endtask

    task automatic test_backpressure();
        int held_ok;
        tick();
        checks++;
        if (iter_valid !== 1'b1 || iter_index !== 3'd0 || iter_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_start: v=%b idx=%0d l=%b want 1 0 0",
                     iter_valid, iter_index, iter_last);
        end
        iter_ready = 1'b1;
        tick();
        checks++;
        if (iter_index !== 3'd1) begin
            errors++;
            $display("FAIL bp_accept1: idx=%0d want 1", iter_index);
        end
        iter_ready = 1'b0;
        held_ok = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (iter_valid === 1'b1 && iter_index === 3'd1 && iter_last === 1'b0) held_ok++;
        end
        checks++;
        if (held_ok != 2) begin
            errors++;
            $display("FAIL bp_stall_hold: stable %0d of 2 idx=%0d want 1", held_ok, iter_index);
        end
        iter_ready = 1'b1;
        tick();
        checks++;
        if (iter_index !== 3'd2 || iter_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept2: v=%b idx=%0d want 1 2", iter_valid, iter_index);
        end
        enable_mask   = 8'h30;
        enable_update = 1'b1;
        tick();
        enable_update = 1'b0;
        checks++;
        if (iter_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_update_wins: v=%b busy=%b want 0 1", iter_valid, busy);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (map_valid !== 1'b1 || enabled_count !== 4'd2 || iter_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_remap: mv=%b cnt=%0d v=%b want 1 2 0",
                     map_valid, enabled_count, iter_valid);
        end
        tick();
        checks++;
        if (iter_valid !== 1'b1 || iter_index !== 3'd4 || iter_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_new_slot0: v=%b idx=%0d l=%b want 1 4 0",
                     iter_valid, iter_index, iter_last);
        end
        tick();
        checks++;
        if (iter_index !== 3'd5 || iter_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_new_slot1: idx=%0d l=%b want 5 1", iter_index, iter_last);
        end
        tick();
        checks++;
        if (iter_index !== 3'd4 || iter_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_new_wrap: idx=%0d l=%b want 4 0", iter_index, iter_last);
        end
        iter_ready = 1'b0;
    endtask

    task automatic test_single();
        enable_mask   = 8'h08;
        enable_update = 1'b1;
        tick();
        enable_update = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        iter_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (iter_valid !== 1'b1 || iter_index !== 3'd3 || iter_last !== 1'b1) begin
                errors++;
                $display("FAIL single[%0d]: v=%b idx=%0d l=%b want 1 3 1",
                         i, iter_valid, iter_index, iter_last);
            end
            tick();
        end
        iter_ready = 1'b0;
    endtask

    task automatic test_mask_no_update();
        enable_mask = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (enabled_count !== 4'd1 || iter_index !== 3'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mask_no_update: cnt=%0d idx=%0d busy=%b want 1 3 0",
                     enabled_count, iter_index, busy);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        enable_mask   = '0;
        enable_update = 1'b0;
        iter_ready    = 1'b0;
        test_reset();
        test_map();
        test_iter();
        test_empty();
        test_restart();
        test_backpressure();
        test_single();
        test_mask_no_update();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
